// File: rtl/mem_seq.sv
// Memory sequencer: arbitrates fetch/data requesters onto a 64-bit big-endian RAM port,
// splitting unaligned accesses into two beats. Define MEM_SEQ_RR_EN for round-robin arbitration.
module mem_seq #(
    parameter int unsigned ADDR_W = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                f_req,
    input  logic [ADDR_W+2:0]   f_addr,
    input  logic [1:0]          f_size,
    output logic                f_ack,
    output logic [63:0]         f_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W+2:0]   d_addr,
    input  logic [1:0]          d_size,
    input  logic [63:0]         d_wdata,
    output logic                d_ack,
    output logic [63:0]         d_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [63:0]         ram_dout,
    output logic [7:0]          ram_mask,
    output logic                ram_we,
    output logic                ram_re,
    input  logic [63:0]         ram_din,
    input  logic                ram_ready
);

    localparam int unsigned BA_W = ADDR_W + 3;

    typedef enum logic [2:0] {S_IDLE, S_CMD1, S_WAIT1, S_CMD2, S_WAIT2, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [BA_W-1:0]     addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                we_q, we_d;
    logic [63:0]         wdata_q, wdata_d;
    logic                gnt_d_q, gnt_d_d;
    logic [63:0]         buf_q, buf_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [63:0]         ram_dout_q, ram_dout_d;
    logic [7:0]          ram_mask_q, ram_mask_d;
    logic                ram_we_q, ram_we_d, ram_re_q, ram_re_d;
    logic                f_ack_q, f_ack_d, d_ack_q, d_ack_d;
    logic [63:0]         f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
`ifdef MEM_SEQ_RR_EN
    logic                last_d_q, last_d_d;
`endif

    logic                pick_d_c;
    logic [BA_W-1:0]     cur_addr_c;
    logic [1:0]          cur_size_c;
    logic                cur_we_c;
    logic [63:0]         cur_wdata_c;
    logic [2:0]          off_c;
    logic [15:0]         top_c, mask16_c;
    logic [63:0]         wtop_c, asm_hi_c, asm_lo_c, t_hi_c, rd_c;
    logic [127:0]        wide_c;
    logic                split_c;

    // Arbitration: a lone requester always wins; ties follow the configured policy
`ifdef MEM_SEQ_RR_EN
    assign pick_d_c = d_req & (~f_req | ~last_d_q);
`else
    assign pick_d_c = d_req;
`endif

    // In IDLE the lane math runs on the incoming request so beat 1 can be registered at grant
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_addr_c  = pick_d_c ? d_addr : f_addr;
            cur_size_c  = pick_d_c ? d_size : f_size;
            cur_we_c    = pick_d_c & d_we;
            cur_wdata_c = d_wdata;
        end else begin
            cur_addr_c  = addr_q;
            cur_size_c  = size_q;
            cur_we_c    = we_q;
            cur_wdata_c = wdata_q;
        end
        off_c = cur_addr_c[2:0];
        case (cur_size_c)
            2'd0:    begin top_c = 16'h8000; wtop_c = {cur_wdata_c[7:0],  56'h0}; end
            2'd1:    begin top_c = 16'hC000; wtop_c = {cur_wdata_c[15:0], 48'h0}; end
            2'd2:    begin top_c = 16'hF000; wtop_c = {cur_wdata_c[31:0], 32'h0}; end
            default: begin top_c = 16'hFF00; wtop_c = cur_wdata_c;               end
        endcase
        mask16_c = top_c >> off_c;
        wide_c   = {wtop_c, 64'h0} >> {off_c, 3'b000};
        split_c  = |mask16_c[7:0];
        asm_hi_c = (state_q == S_WAIT1) ? ram_din : buf_q;
        asm_lo_c = (state_q == S_WAIT2) ? ram_din : 64'h0;
        t_hi_c   = 64'(({asm_hi_c, asm_lo_c} << {off_c, 3'b000}) >> 64);
        case (cur_size_c)
            2'd0:    rd_c = {56'h0, t_hi_c[63:56]};
            2'd1:    rd_c = {48'h0, t_hi_c[63:48]};
            2'd2:    rd_c = {32'h0, t_hi_c[63:32]};
            default: rd_c = t_hi_c;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        gnt_d_d    = gnt_d_q;
        buf_d      = buf_q;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        ram_mask_d = ram_mask_q;
        ram_we_d   = 1'b0;
        ram_re_d   = 1'b0;
        f_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_SEQ_RR_EN
        last_d_d   = last_d_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (d_req | f_req) begin
                    state_d    = S_CMD1;
                    addr_d     = cur_addr_c;
                    size_d     = cur_size_c;
                    we_d       = cur_we_c;
                    wdata_d    = cur_wdata_c;
                    gnt_d_d    = pick_d_c;
`ifdef MEM_SEQ_RR_EN
                    last_d_d   = pick_d_c;
`endif
                    ram_addr_d = cur_addr_c[BA_W-1:3];
                    ram_mask_d = mask16_c[15:8];
                    ram_dout_d = cur_we_c ? wide_c[127:64] : 64'h0;
                    ram_we_d   = cur_we_c;
                    ram_re_d   = ~cur_we_c;
                end
            end
            S_CMD1, S_CMD2: begin
                if (ram_ready) begin
                    state_d = (state_q == S_CMD1) ? S_WAIT1 : S_WAIT2;
                end else begin
                    ram_we_d = ram_we_q;
                    ram_re_d = ram_re_q;
                end
            end
            S_WAIT1, S_WAIT2: begin
                if (ram_ready) begin
                    if (state_q == S_WAIT1 && split_c) begin
                        state_d    = S_CMD2;
                        buf_d      = ram_din;
                        ram_addr_d = ram_addr_q + ADDR_W'(1);
                        ram_mask_d = mask16_c[7:0];
                        ram_dout_d = we_q ? wide_c[63:0] : 64'h0;
                        ram_we_d   = we_q;
                        ram_re_d   = ~we_q;
                    end else begin
                        state_d = S_RESP;
                        d_ack_d = gnt_d_q;
                        f_ack_d = ~gnt_d_q;
                        if (gnt_d_q) d_rdata_d = we_q ? 64'h0 : rd_c;
                        else         f_rdata_d = rd_c;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            gnt_d_q    <= 1'b0;
            buf_q      <= '0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_mask_q <= '0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_SEQ_RR_EN
            last_d_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            gnt_d_q    <= gnt_d_d;
            buf_q      <= buf_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            ram_mask_q <= ram_mask_d;
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
            f_ack_q    <= f_ack_d;
            d_ack_q    <= d_ack_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_SEQ_RR_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    assign f_ack    = f_ack_q;
    assign f_rdata  = f_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_rdata  = d_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign ram_mask = ram_mask_q;
    assign ram_we   = ram_we_q;
    assign ram_re   = ram_re_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq with a one-cycle-busy RAM model and hand-computed expectations.
module tb_mem_seq;
    localparam int unsigned AW = 28;

    logic            clk = 1'b0;
    logic            rst;
    logic            f_req, d_req, d_we;
    logic [AW+2:0]   f_addr, d_addr;
    logic [1:0]      f_size, d_size;
    logic [63:0]     d_wdata;
    logic            f_ack, d_ack;
    logic [63:0]     f_rdata, d_rdata;
    logic [AW-1:0]   ram_addr;
    logic [63:0]     ram_dout, ram_din;
    logic [7:0]      ram_mask;
    logic            ram_we, ram_re, ram_ready;
    logic            rdy_q, stall;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int f_ack_n = 0;
    int d_ack_n = 0;
    int acc_n = 0;
    logic [AW-1:0]   acc_addr [64];
    logic [7:0]      acc_mask [64];
    logic [63:0]     acc_dout [64];
    logic [63:0]     mem [logic [AW-1:0]];

    mem_seq #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_size(f_size), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_mask(ram_mask),
        .ram_we(ram_we), .ram_re(ram_re), .ram_din(ram_din), .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (f_ack) f_ack_n++;
        if (d_ack) d_ack_n++;
    end

    assign ram_ready = rdy_q & ~stall;

    function automatic logic [63:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    // RAM: accepts when ready, busy one cycle, read data valid when ready returns
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q   <= 1'b1;
            ram_din <= 64'h0;
        end else if (ram_ready && (ram_re || ram_we)) begin
            logic [63:0] v;
            rdy_q <= 1'b0;
            acc_addr[acc_n % 64] = ram_addr;
            acc_mask[acc_n % 64] = ram_mask;
            acc_dout[acc_n % 64] = ram_dout;
            acc_n++;
            if (ram_we) begin
                v = mem_rd(ram_addr);
                for (int i = 0; i < 8; i++)
                    if (ram_mask[7-i]) v[63-8*i -: 8] = ram_dout[63-8*i -: 8];
                mem[ram_addr] = v;
            end else begin
                ram_din <= mem_rd(ram_addr);
            end
        end else if (!rdy_q) begin
            rdy_q <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input int t0, output int lat, output bit is_d);
        int k = 0;
        while (!(f_ack || d_ack) && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_ack"}, 64'(f_ack | d_ack), 64'd1);
        lat  = cyc - t0;
        is_d = d_ack;
    endtask

    task automatic access(input string tag, input bit dport, input bit we, input logic [AW+2:0] addr,
                          input logic [1:0] size, input logic [63:0] wd,
                          output int lat, output logic [63:0] rdata);
        int t0;
        bit isd;
        t0 = cyc;
        if (dport) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_wdata = wd;
        end else begin
            f_req = 1'b1; f_addr = addr; f_size = size;
        end
        wait_ack(tag, t0, lat, isd);
        rdata = dport ? d_rdata : f_rdata;
        d_req = 1'b0;
        f_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {62'h0, ram_re, ram_we}, 64'h0);
        chk("rst_acks",    {62'h0, f_ack, d_ack}, 64'h0);
        chk("rst_ram",     {28'h0, ram_addr, ram_mask} | ram_dout, 64'h0);
        chk("rst_rdata",   f_rdata | d_rdata, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, base, dn, k;
        bit isd;
        logic [63:0] rd;

        rst = 1'b1; stall = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; f_size = '0; d_size = '0; d_wdata = '0;
        mem[28'd2]         = 64'h0011223344556677;
        mem[28'd1]         = 64'h1111111111111111;
        mem[28'hFFFFFFF]   = 64'h0102030405060708;
        mem[28'd0]         = 64'hA1B2C3D4E5F60718;
        do_reset();

        // unsplit load
        base = acc_n;
        access("ld4", 1'b1, 1'b0, 31'h10, 2'd2, 64'h0, lat, rd);
        chk("ld4_lat",   64'(lat), 64'd4);
        chk("ld4_data",  rd, 64'h0000000000112233);
        chk("ld4_beats", 64'(acc_n - base), 64'd1);
        chk("ld4_addr",  64'(acc_addr[base % 64]), 64'd2);
        chk("ld4_mask",  64'(acc_mask[base % 64]), 64'hF0);

        // aligned doubleword fetch
        access("f8", 1'b0, 1'b0, 31'h10, 2'd3, 64'h0, lat, rd);
        chk("f8_lat",  64'(lat), 64'd4);
        chk("f8_data", rd, 64'h0011223344556677);

        // split store
        base = acc_n; dn = d_ack_n;
        access("st", 1'b1, 1'b1, 31'h0E, 2'd2, 64'hAABBCCDD, lat, rd);
        chk("st_lat",   64'(lat), 64'd7);
        chk("st_beats", 64'(acc_n - base), 64'd2);
        chk("st_a1",    64'(acc_addr[base % 64]), 64'd1);
        chk("st_m1",    64'(acc_mask[base % 64]), 64'h03);
        chk("st_d1",    acc_dout[base % 64], 64'h000000000000AABB);
        chk("st_a2",    64'(acc_addr[(base + 1) % 64]), 64'd2);
        chk("st_m2",    64'(acc_mask[(base + 1) % 64]), 64'hC0);
        chk("st_d2",    acc_dout[(base + 1) % 64], 64'hCCDD000000000000);
        chk("st_rdata", rd, 64'h0);
        chk("st_acks",  64'(d_ack_n - dn), 64'd1);

        // split load reads back the store
        access("ld8", 1'b1, 1'b0, 31'h0E, 2'd3, 64'h0, lat, rd);
        chk("ld8_lat",  64'(lat), 64'd7);
        chk("ld8_data", rd, 64'hAABBCCDD22334455);

        // split fetch wrapping past the top doubleword
        base = acc_n;
        access("wrap", 1'b0, 1'b0, {28'hFFFFFFF, 3'd7}, 2'd1, 64'h0, lat, rd);
        chk("wrap_lat",  64'(lat), 64'd7);
        chk("wrap_data", rd, 64'h00000000000008A1);
        chk("wrap_a1",   64'(acc_addr[base % 64]), 64'hFFFFFFF);
        chk("wrap_a2",   64'(acc_addr[(base + 1) % 64]), 64'd0);
        chk("wrap_m",    64'({acc_mask[base % 64], acc_mask[(base + 1) % 64]}), 64'h0180);

        // RAM stalls acceptance for five cycles
        base = acc_n;
        begin
            int t0;
            t0 = cyc;
            d_req = 1'b1; d_we = 1'b0; d_addr = 31'h10; d_size = 2'd2;
            stall = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < 5; i++) begin
                chk("stall_re", 64'(ram_re), 64'd1);
                @(posedge clk); #1;
            end
            stall = 1'b0;
            wait_ack("stall", t0, lat, isd);
            chk("stall_lat",  64'(lat), 64'd9);
            chk("stall_data", d_rdata, 64'h00000000CCDD2233);
            chk("stall_beats", 64'(acc_n - base), 64'd1);
            d_req = 1'b0;
            @(posedge clk); #1;
        end

        // contention from reset state
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 31'h10; d_size = 2'd3;
        f_req = 1'b1; f_addr = 31'h08; f_size = 2'd3;
        for (int i = 0; i < 4; i++) begin
            bit exp_d;
`ifdef MEM_SEQ_RR_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            wait_ack("cont", cyc, lat, isd);
            chk("cont_winner", 64'(isd), 64'(exp_d));
            if (i == 3) begin
                d_req = 1'b0; f_req = 1'b0;
            end
            @(posedge clk); #1;
        end

        // reset during the second beat of a split store
        @(posedge clk); #1;
        base = acc_n; dn = d_ack_n;
        d_req = 1'b1; d_we = 1'b1; d_addr = 31'h0E; d_size = 2'd2; d_wdata = 64'h55667788;
        k = 0;
        while (acc_n != base + 2 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reach", 64'(acc_n - base), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("abort_we",   64'(ram_we), 64'd0);
        chk("abort_acks", {62'h0, f_ack, d_ack}, 64'h0);
        chk("abort_mask", 64'(ram_mask), 64'h0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_noack", 64'(d_ack_n - dn), 64'd0);
        chk("abort_idle",  {62'h0, ram_re, ram_we}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
